pc_fetch: RTL and testbench
===========================

// Module: pc_fetch
// PURPOSE
//  Program-counter and instruction-fetch stage of the single-cycle RISC-V core; feeds Instr to the control decoder and datapath.
//  Holds PC, fetches over a req/ack instruction-memory handshake and presents one instruction at a time.
//  Advances to PC+4, or to PC+ImmExt when the core retires a taken branch (PCSrc).
//  Keeps a retired-instruction counter for performance checks.
// PARAMETERS
//  XLEN      32          address/data width of PC and ImmExt
//  RESET_PC  32'h0       PC value loaded on reset
//  CNT_W     32          width of RetireCount
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      reset, asynchronous, active-low
//  ImemReq      out  1      fetch request to instruction memory
//  ImemAddr     out  XLEN   fetch address (equals PC)
//  ImemAck      in   1      memory returns ImemRData this cycle
//  ImemRData    in   32     fetched instruction word
//  Instr        out  32     instruction presented to decode
//  InstrValid   out  1      Instr/PC valid for execution
//  PC           out  XLEN   address of Instr
//  PCPlus4      out  XLEN   PC+4 (combinational, for JAL-style writeback)
//  Retire       in   1      core finished Instr this cycle (honoured only when InstrValid)
//  PCSrc        in   1      taken branch, sampled with Retire
//  ImmExt       in   XLEN   sign-extended branch offset, sampled with Retire
//  Misaligned   out  1      sticky: taken branch target not word-aligned
//  RetireCount  out  CNT_W  instructions retired since reset
// BEHAVIOUR
//  Reset (async assert, any state): state=BOOT, PC=RESET_PC, Instr=0, InstrValid=0, ImemReq=0,
//   Misaligned=0, RetireCount=0. Outputs take these values immediately, without a clock edge.
//  States:
//   BOOT  - one cycle after reset release, ImemReq=0; next FETCH.
//   FETCH - ImemReq=1, ImemAddr=PC; ImemAddr held stable while waiting.
//           ImemAck=1: capture ImemRData into Instr; next EXEC.
//           ImemAck=0: stay.
//   EXEC  - InstrValid=1, ImemReq=0, Instr/PC held.
//           Retire=0: stay.
//           Retire=1: RetireCount+=1. Next PC = PCSrc ? PC+ImmExt : PC+4.
//             If PCSrc=1 and (PC+ImmExt)[1:0]!=0: Misaligned=1, PC unchanged, next HALT.
//             Otherwise: next FETCH.
//   HALT  - InstrValid=0, ImemReq=0; only reset exits.
//  Minimum latency: FETCH with same-cycle ack -> EXEC on next edge, so 2 cycles/instruction
//   for zero-wait memory.
//  Arithmetic: PC+4 and PC+ImmExt are modulo 2^XLEN; 0xFFFFFFFC+4 wraps to 0.
//  RetireCount wraps from all-ones to 0.
//  Retire, PCSrc and ImmExt are ignored outside EXEC. ImemAck is ignored outside FETCH.
//  Reset mid-fetch drops ImemReq asynchronously; a late ImemAck after release is ignored (state BOOT).
//  InstrValid is registered and never asserted in the same cycle as ImemReq.
// TESTING
//  T1 reset, RESET_PC=0, ack same cycle, 3 retires, PCSrc=0
//     -> ImemAddr 0,4,8,C; RetireCount=3; InstrValid low during each FETCH.
//  T2 at PC=0x10, retire with PCSrc=1, ImmExt=0xFFFFFFF8
//     -> next ImemAddr=0x08; then ImmExt=0x20 from 0x08 -> 0x28.
//  T3 ack delayed 5 cycles -> ImemReq high 6 cycles, ImemAddr stable; Instr updates only on the ack edge.
//  T4 PCSrc=1, ImmExt=0x6 at PC=0x40 -> Misaligned=1, HALT, PC=0x40, no further ImemReq; rst_n low clears it.
//  T5 rst_n low mid-FETCH -> ImemReq=0 immediately; ack on the first post-release cycle ignored;
//     fetch restarts at RESET_PC.
//  T6 PC=0xFFFFFFFC retire, PCSrc=0 -> ImemAddr=0x0; preload RetireCount to all-ones, retire -> 0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// ============================================================================
//  Module      : pc_fetch_if
//  Description : Fetch-stage bundle: instruction-memory handshake, decode-side
//                instruction/PC outputs, and retire/branch inputs from the core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pc_fetch_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic              ImemReq;
    logic [XLEN-1:0]   ImemAddr;
    logic              ImemAck;
    logic [31:0]       ImemRData;
    logic [31:0]       Instr;
    logic              InstrValid;
    logic [XLEN-1:0]   PC;
    logic [XLEN-1:0]   PCPlus4;
    logic              Retire;
    logic              PCSrc;
    logic [XLEN-1:0]   ImmExt;
    logic              Misaligned;
    logic [CNT_W-1:0]  RetireCount;

    modport master (
        output ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus4, Misaligned, RetireCount,
        input  ImemAck, ImemRData, Retire, PCSrc, ImmExt
    );

    modport slave (
        input  ImemReq, ImemAddr, Instr, InstrValid, PC, PCPlus4, Misaligned, RetireCount,
        output ImemAck, ImemRData, Retire, PCSrc, ImmExt
    );
endinterface

`default_nettype wire

// File: rtl/pc_fetch.sv
// ============================================================================
//  Module      : pc_fetch
//  Description : Program counter and instruction fetch for the single-cycle core.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    pc_fetch_if.master  bus
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_nxt;
    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_target;
    logic [31:0]       r_instr;
    logic [31:0]       w_instr_nxt;
    logic              r_valid;
    logic              w_valid_nxt;
    logic              r_mis;
    logic              w_mis_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;

    assign w_pc_plus4 = r_pc + XLEN'(4);
    assign w_target   = r_pc + bus.ImmExt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
            r_valid <= w_valid_nxt;
            r_mis   <= w_mis_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_mis_nxt   = r_mis;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_BOOT: w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (bus.ImemAck) begin
                    w_instr_nxt = bus.ImemRData;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (bus.Retire) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    // A misaligned taken target freezes PC at the offending branch.
                    if (bus.PCSrc && (w_target[1:0] != 2'b00)) begin
                        w_mis_nxt   = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt    = bus.PCSrc ? w_target : w_pc_plus4;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            default: w_state_nxt = ST_HALT;
        endcase
        w_valid_nxt = (w_state_nxt == ST_EXEC);
    end

    assign bus.ImemReq     = (r_state == ST_FETCH);
    assign bus.ImemAddr    = r_pc;
    assign bus.PC          = r_pc;
    assign bus.PCPlus4     = w_pc_plus4;
    assign bus.Instr       = r_instr;
    assign bus.InstrValid  = r_valid;
    assign bus.Misaligned  = r_mis;
    assign bus.RetireCount = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
// ============================================================================
//  Module      : tb_pc_fetch
//  Description : Self-checking bench for pc_fetch with a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_fetch;

    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_fetch_if #(.XLEN(32), .CNT_W(CW)) bus ();

    pc_fetch #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference model: phase flags (boot / waiting for memory / holding an instruction);
    // none set means halted.
    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    logic [CW-1:0] m_cnt;
    logic          m_mis, m_boot, m_fetch, m_exec;
    wire  [31:0]   m_tgt = bus.PCSrc ? (m_pc + bus.ImmExt) : (m_pc + 32'd4);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_cnt <= '0; m_mis <= 1'b0;
            m_boot <= 1'b1; m_fetch <= 1'b0; m_exec <= 1'b0;
        end else if (m_boot) begin
            m_boot <= 1'b0; m_fetch <= 1'b1;
        end else if (m_fetch) begin
            if (bus.ImemAck) begin
                m_instr <= bus.ImemRData; m_fetch <= 1'b0; m_exec <= 1'b1;
            end
        end else if (m_exec && bus.Retire) begin
            m_cnt  <= m_cnt + 1'b1;
            m_exec <= 1'b0;
            if (bus.PCSrc && (m_tgt[1:0] != 2'b00)) m_mis <= 1'b1;
            else begin
                m_pc <= m_tgt; m_fetch <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("ImemReq",     64'(bus.ImemReq),     64'(m_fetch));
        chk("ImemAddr",    64'(bus.ImemAddr),    64'(m_pc));
        chk("PC",          64'(bus.PC),          64'(m_pc));
        chk("PCPlus4",     64'(bus.PCPlus4),     64'(32'(m_pc + 32'd4)));
        chk("Instr",       64'(bus.Instr),       64'(m_instr));
        chk("InstrValid",  64'(bus.InstrValid),  64'(m_exec));
        chk("Misaligned",  64'(bus.Misaligned),  64'(m_mis));
        chk("RetireCount", 64'(bus.RetireCount), 64'(m_cnt));
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    // Drive one cycle's inputs at a negedge; return at the next negedge.
    task automatic cyc(input logic a, input logic [31:0] d, input logic r, input logic s,
                       input logic [31:0] imm);
        bus.ImemAck = a; bus.ImemRData = d; bus.Retire = r; bus.PCSrc = s; bus.ImmExt = imm;
        @(negedge clk);
    endtask

    task automatic fetch_retire(input logic [31:0] d, input logic s, input logic [31:0] imm);
        cyc(1'b1, d, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b1, s, imm);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst ImemReq",     64'(bus.ImemReq),     64'h0);
        chk("rst InstrValid",  64'(bus.InstrValid),  64'h0);
        chk("rst PC",          64'(bus.PC),          64'h0);
        chk("rst Instr",       64'(bus.Instr),       64'h0);
        chk("rst Misaligned",  64'(bus.Misaligned),  64'h0);
        chk("rst RetireCount", 64'(bus.RetireCount), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int reqcnt;
        int halt_cyc;
        bus.ImemAck = 1'b0; bus.ImemRData = 32'h0; bus.Retire = 1'b0;
        bus.PCSrc = 1'b0; bus.ImmExt = 32'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        do_reset();

        // Sequential fetch with same-cycle ack; ack during boot is ignored.
        cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        chk("boot ack ignored", 64'(bus.Instr), 64'h0);
        chk("first req",        64'(bus.ImemReq), 64'h1);
        chk("first addr",       64'(bus.ImemAddr), 64'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 32'h1000_0000 + k, 1'b0, 1'b0, 32'h0);
            chk("instr capture", 64'(bus.Instr), 64'(32'h1000_0000 + k));
            chk("valid no req",  64'({bus.InstrValid, bus.ImemReq}), 64'h2);
            cyc(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
            chk("seq addr", 64'(bus.ImemAddr), 64'(4 * (k + 1)));
        end
        chk("count 3", 64'(bus.RetireCount), 64'h3);

        // Taken branches: 0x10 - 8 -> 0x08, then +0x20 -> 0x28.
        fetch_retire(32'h0000_0013, 1'b0, 32'h0);
        fetch_retire(32'h0000_0063, 1'b1, 32'hFFFF_FFF8);
        chk("branch back", 64'(bus.ImemAddr), 64'h8);
        fetch_retire(32'h0000_0063, 1'b1, 32'h0000_0020);
        chk("branch fwd", 64'(bus.ImemAddr), 64'h28);

        // Ack delayed five cycles.
        reqcnt = 32'(bus.ImemReq);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 32'h5555_5555, 1'b1, 1'b1, 32'h4);
            reqcnt += 32'(bus.ImemReq);
            chk("wait addr stable", 64'(bus.ImemAddr), 64'h28);
            chk("wait instr held",  64'(bus.Instr), 64'h0000_0063);
        end
        cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 32'h0);
        reqcnt += 32'(bus.ImemReq);
        chk("req high cycles", 64'(reqcnt), 64'd6);
        chk("late ack instr",  64'(bus.Instr), 64'hA5A5_0001);

        // PC wrap at the top of the address space.
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFD4);
        chk("top addr", 64'(bus.ImemAddr), 64'hFFFF_FFFC);
        chk("top plus4", 64'(bus.PCPlus4), 64'h0);
        fetch_retire(32'h0000_0013, 1'b0, 32'h0);
        chk("wrap addr", 64'(bus.ImemAddr), 64'h0);
        chk("count 8",   64'(bus.RetireCount), 64'h8);

        // Misaligned branch target halts.
        fetch_retire(32'h0000_0063, 1'b1, 32'h0000_0040);
        chk("addr 40", 64'(bus.ImemAddr), 64'h40);
        fetch_retire(32'h0000_0063, 1'b1, 32'h0000_0006);
        chk("misaligned set", 64'(bus.Misaligned), 64'h1);
        chk("halt pc",        64'(bus.PC), 64'h40);
        for (int k = 0; k < 4; k++) cyc(1'b1, 32'h1, 1'b1, 1'b0, 32'h0);
        chk("halt no req", 64'({bus.ImemReq, bus.InstrValid}), 64'h0);
        do_reset();

        // Reset mid-fetch; ack right after release is ignored.
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.ImemAck = 1'b1;
        do_reset();
        cyc(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b0, 32'h0);
        chk("post-rst ack ignored", 64'(bus.Instr), 64'h0);
        chk("restart addr",         64'(bus.ImemAddr), 64'h0);
        chk("restart req",          64'(bus.ImemReq), 64'h1);

        // Retire counter wraps.
        for (int k = 0; k < 255; k++) fetch_retire(32'(k), 1'b0, 32'h0);
        chk("count ff", 64'(bus.RetireCount), 64'hFF);
        fetch_retire(32'h0, 1'b0, 32'h0);
        chk("count wrap", 64'(bus.RetireCount), 64'h0);
        chk("addr 400",   64'(bus.ImemAddr), 64'h400);

        // Randomised traffic.
        do_reset();
        halt_cyc = 0;
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] imm;
            logic        s;
            s = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) imm = $urandom;
            else imm = 32'(($urandom_range(0, 63) - 32) * 4);
            if (!m_boot && !m_fetch && !m_exec) halt_cyc++;
            if (halt_cyc > 3 || $urandom_range(0, 299) == 0) begin
                halt_cyc = 0;
                bus.ImemAck = $urandom_range(0, 1) == 1;
                do_reset();
            end else begin
                cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 1) == 1, s, imm);
            end
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
